// File: rtl/pipeline_hazard_ctrl_if.sv
// Control-path bundle between the ID/EX pipeline registers and the stall/flush sequencer.
// master = pipeline datapath side, slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic             id_valid;
   logic [4:0]       id_rd;
   logic [4:0]       id_rn;
   logic [4:0]       id_rm;
   logic             id_uses_rn;
   logic             id_uses_rm;
   logic             id_reg_write;
   logic             id_is_load;
   logic             id_flag_en;
   logic             id_reads_flags;
   logic             id_is_branch;
   logic             ex_br_resolved;
   logic             ex_br_taken;
   logic             pc_en;
   logic             pc_load_target;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_bubble;
   logic [2:0]       state;
   logic [CNT_W-1:0] stall_count;
   logic             br_timeout_err;

   modport master (
      output id_valid, id_rd, id_rn, id_rm, id_uses_rn, id_uses_rm, id_reg_write,
             id_is_load, id_flag_en, id_reads_flags, id_is_branch,
             ex_br_resolved, ex_br_taken,
      input  pc_en, pc_load_target, ifid_en, ifid_flush, idex_bubble,
             state, stall_count, br_timeout_err
   );

   modport slave (
      input  id_valid, id_rd, id_rn, id_rm, id_uses_rn, id_uses_rm, id_reg_write,
             id_is_load, id_flag_en, id_reads_flags, id_is_branch,
             ex_br_resolved, ex_br_taken,
      output pc_en, pc_load_target, ifid_en, ifid_flush, idex_bubble,
             state, stall_count, br_timeout_err
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage CPU: load-use and flag hazards, branch wait/redirect,
// and branch-timeout lockup. Pipeline-control outputs are combinational from state and inputs.
module pipeline_hazard_ctrl #(
   parameter int unsigned BR_TIMEOUT = 8,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned ZERO_REG   = 31
) (
   input  logic                   clk,
   input  logic                   reset,
   pipeline_hazard_ctrl_if.slave  hz
);
   localparam int unsigned TMR_W = $clog2(BR_TIMEOUT) + 1;
   localparam logic [4:0]  ZR    = 5'(ZERO_REG);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BR_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   localparam logic [2:0] RUN     = 3'd0;
   localparam logic [2:0] BR_WAIT = 3'd1;
   localparam logic [2:0] ERR     = 3'd2;

   logic [2:0]       state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             err_q, err_d;
   logic [4:0]       ex_rd_q;
   logic             ex_load_q;
   logic             ex_flagset_q;

   logic pc_en, pc_load_target, ifid_en, ifid_flush, idex_bubble;
   logic load_haz, flag_haz, issue;

   // Shadow of what sits in EX: only a load whose Rd is a real register can stall ID.
   assign load_haz = hz.id_valid & ex_load_q & (ex_rd_q != ZR) &
                     ((hz.id_uses_rn & (hz.id_rn == ex_rd_q)) |
                      (hz.id_uses_rm & (hz.id_rm == ex_rd_q)));
   assign flag_haz = hz.id_valid & hz.id_reads_flags & ex_flagset_q;
   assign issue    = hz.id_valid & ~idex_bubble;

   always_comb begin
      pc_en          = 1'b0;
      pc_load_target = 1'b0;
      ifid_en        = 1'b0;
      ifid_flush     = 1'b0;
      idex_bubble    = 1'b0;
      state_d        = state_q;
      tmr_d          = tmr_q;
      err_d          = err_q;
      if (reset) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               if (load_haz | flag_haz) begin
                  idex_bubble = 1'b1;
               end else if (hz.id_valid & hz.id_is_branch) begin
                  // Branch goes to EX; the fall-through fetch behind it is discarded.
                  ifid_flush = 1'b1;
                  tmr_d      = '0;
                  state_d    = BR_WAIT;
               end else begin
                  pc_en   = 1'b1;
                  ifid_en = 1'b1;
               end
            end
            BR_WAIT: begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               tmr_d       = tmr_q + TMR_W'(1);
               if (hz.ex_br_resolved) begin
                  pc_en          = 1'b1;
                  pc_load_target = hz.ex_br_taken;
                  state_d        = RUN;
               end else if (tmr_q == TMR_LAST) begin
                  err_d   = 1'b1;
                  state_d = ERR;
               end
            end
            ERR: begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               err_d       = 1'b1;
            end
            default: begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               state_d     = RUN;
            end
         endcase
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (((state_q == RUN) || (state_q == BR_WAIT)) && !pc_en && (stall_q != CNT_MAX))
         stall_d = stall_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= RUN;
         tmr_q        <= '0;
         stall_q      <= '0;
         err_q        <= 1'b0;
         ex_rd_q      <= ZR;
         ex_load_q    <= 1'b0;
         ex_flagset_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         tmr_q        <= tmr_d;
         stall_q      <= stall_d;
         err_q        <= err_d;
         ex_rd_q      <= (issue & hz.id_reg_write) ? hz.id_rd : ZR;
         ex_load_q    <= issue & hz.id_is_load;
         ex_flagset_q <= issue & hz.id_flag_en;
      end
   end

   assign hz.pc_en          = pc_en;
   assign hz.pc_load_target = pc_load_target;
   assign hz.ifid_en        = ifid_en;
   assign hz.ifid_flush     = ifid_flush;
   assign hz.idex_bubble    = idex_bubble;
   assign hz.state          = state_q;
   assign hz.stall_count    = stall_q;
   assign hz.br_timeout_err = err_q;
endmodule
